// File: rtl/tone_div_ctrl.sv
// Note-to-tone controller: priority-selects one of 8 key requests, maps it to an
// octave-scaled half-period divisor and drives a glitch-free square-wave tone.
module tone_div_ctrl #(
    parameter int CNT_W = 19,
    parameter int OCT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       key,
    input  logic [OCT_W-1:0] oct,
    output logic             tone_out,
    output logic             busy,
    output logic [2:0]       active_key,
    output logic [CNT_W-1:0] div_cnt,
    output logic [CNT_W-1:0] cur_div
);

    // state   | meaning
    // IDLE    | silent, counter held at 0, waiting for a key
    // RUN     | tone sounding, pitch may change at each wrap
    // DRAIN   | keys released on a low half, finishing the last high half

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [2:0]       sel;
    logic             req;
    logic [CNT_W-1:0] nd;
    logic             wrap;

    // Half-period counts for the 8 notes at a 50 MHz clock.
    function automatic logic [CNT_W-1:0] base_div(input logic [2:0] idx);
        logic [CNT_W-1:0] v;
        case (idx)
            3'd0:    v = CNT_W'(95556);
            3'd1:    v = CNT_W'(85131);
            3'd2:    v = CNT_W'(75843);
            3'd3:    v = CNT_W'(71586);
            3'd4:    v = CNT_W'(63776);
            3'd5:    v = CNT_W'(56818);
            3'd6:    v = CNT_W'(50619);
            default: v = CNT_W'(47778);
        endcase
        return v;
    endfunction

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (key[i]) sel = 3'(i);
        end
    end

    assign req  = |key;
    assign nd   = base_div(sel) >> oct;
    assign wrap = (div_cnt == cur_div - CNT_W'(1));
    assign busy = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            tone_out   <= 1'b0;
            active_key <= 3'd0;
            div_cnt    <= '0;
            cur_div    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_cnt  <= '0;
                    tone_out <= 1'b0;
                    if (req) begin
                        cur_div    <= nd;
                        active_key <= sel;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wrap) begin
                        div_cnt  <= '0;
                        tone_out <= ~tone_out;
                        if (req) begin
                            cur_div    <= nd;
                            active_key <= sel;
                        end else if (tone_out) begin
                            state <= S_IDLE;
                        end else begin
                            // going high with no key: one more half period to end low
                            state <= S_DRAIN;
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (wrap) begin
                        div_cnt  <= '0;
                        tone_out <= ~tone_out;
                        if (req) begin
                            cur_div    <= nd;
                            active_key <= sel;
                            state      <= S_RUN;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
